instruction_fetch_unit: RTL

//   Fetch stage of the MIPS CPU: owns the PC register, drives the combinational instruction ROM address,
//   and latches the returned instruction into the IF/ID pipeline register for the decoder.

---
 rtl/instruction_fetch_unit_if.sv | 38 +++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module   : instruction_fetch_unit_if
// Purpose  : Control, instruction-memory and IF/ID signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic        jump_reg;
   logic [31:0] jr_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        irq;
   logic [31:0] epc;

   modport slave (
      input  stall, flush, branch_taken, branch_target, jump, jump_index,
             jump_reg, jr_target, imem_instr, irq,
      output imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc
   );

   modport master (
      output stall, flush, branch_taken, branch_target, jump, jump_index,
             jump_reg, jr_target, imem_instr, irq,
      input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, epc
   );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : MIPS fetch stage - PC, next-PC select, IF/ID register.
//            Define IRQ_EN to enable interrupt entry (epc / IRQ_VECTOR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   instruction_fetch_unit_if.slave   bus
);

   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;

   logic [31:0] w_pc4;
   logic [31:0] w_jump_target;
   logic        w_redirect;
   logic        w_irq_take;
   logic [31:0] w_pc_next;
   logic        w_ifid_hold;
   logic        w_ifid_bubble;
   logic        w_unused;

   assign w_pc4         = r_pc + 32'd4;
   assign w_jump_target = {bus.ifid_pc4[31:28], bus.jump_index, 2'b00};
   assign w_redirect    = bus.branch_taken | bus.jump_reg | bus.jump;

`ifdef IRQ_EN
   logic [31:0] r_epc;

   // Interrupts are only taken from user space on an otherwise quiet cycle.
   assign w_irq_take = bus.irq & ~r_pc[31] & ~bus.stall & ~w_redirect;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_epc <= 32'h0;
      end else if (w_irq_take) begin
         r_epc <= r_pc;
      end
   end

   assign bus.epc = r_epc;
   assign w_unused = ^{bus.branch_target[1:0], bus.jr_target[1:0],
                       bus.ifid_pc4[27:0], IRQ_VECTOR[1:0]};
`else
   assign w_irq_take = 1'b0;
   assign bus.epc    = 32'h0;
   assign w_unused   = ^{bus.branch_target[1:0], bus.jr_target[1:0],
                         bus.ifid_pc4[27:0], bus.irq, IRQ_VECTOR};
`endif

   // Priority: irq > branch > jump_reg > jump > stall > pc+4.
   always_comb begin
      w_pc_next     = w_pc4;
      w_ifid_hold   = 1'b0;
      w_ifid_bubble = bus.flush;
      if (w_irq_take) begin
         w_pc_next     = {IRQ_VECTOR[31:2], 2'b00};
         w_ifid_bubble = 1'b1;
      end else if (bus.branch_taken) begin
         w_pc_next     = {bus.branch_target[31:2], 2'b00};
         w_ifid_bubble = 1'b1;
      end else if (bus.jump_reg) begin
         w_pc_next     = {bus.jr_target[31:2], 2'b00};
         w_ifid_bubble = 1'b1;
      end else if (bus.jump) begin
         w_pc_next     = w_jump_target;
         w_ifid_bubble = 1'b1;
      end else if (bus.stall) begin
         w_pc_next     = r_pc;
         w_ifid_hold   = ~bus.flush;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ifid_instr <= 32'h0;
         r_ifid_pc4   <= 32'h0;
         r_ifid_valid <= 1'b0;
      end else if (w_ifid_bubble) begin
         r_ifid_instr <= 32'h0;
         r_ifid_pc4   <= 32'h0;
         r_ifid_valid <= 1'b0;
      end else if (!w_ifid_hold) begin
         r_ifid_instr <= bus.imem_instr;
         r_ifid_pc4   <= w_pc4;
         r_ifid_valid <= 1'b1;
      end
   end

   assign bus.imem_addr  = r_pc;
   assign bus.ifid_instr = r_ifid_instr;
   assign bus.ifid_pc4   = r_ifid_pc4;
   assign bus.ifid_valid = r_ifid_valid;

endmodule

`default_nettype wire
